// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : requester, RAM and status signals of the two-port arbiter
// Revision 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  // Requesters and RAM model side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data arbiter onto a single-port RAM, one access in flight
// Revision 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mem_arbiter_if.slave   bus
);
  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAT_LAST   = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        starve_cnt;
  logic [1:0]        lat_cnt;
  logic              owner_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              mem_en_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;

  logic              i_win;
  logic              d_win;

  // Grants are combinational in IDLE; rst gating keeps them low while reset is held
  assign i_win = (state == IDLE) && !rst && bus.i_req &&
                 (!bus.d_req || (starve_cnt == STARVE_LIM));
  assign d_win = (state == IDLE) && !rst && bus.d_req && !i_win;

  assign bus.i_gnt     = i_win;
  assign bus.d_gnt     = d_win;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_en_q & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rvalid_q ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (d_rvalid_q && !we_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_en_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            state    <= ACCESS;
            mem_en_q <= 1'b1;
            owner_d  <= 1'b1;
            we_q     <= bus.d_we;
            addr_q   <= bus.d_addr;
            wdata_q  <= bus.d_wdata;
            be_q     <= bus.d_be;
            if (bus.i_req) begin
              if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (i_win) begin
            state      <= ACCESS;
            mem_en_q   <= 1'b1;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= bus.i_addr;
            wdata_q    <= '0;
            be_q       <= '1;
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          state   <= WAIT;
          lat_cnt <= LAT_LAST;
          if (LAT_LAST == 2'd0) begin
            i_rvalid_q <= !owner_d;
            d_rvalid_q <= owner_d;
          end
        end
        WAIT: begin
          // The last WAIT cycle (lat_cnt == 0) is the completion cycle
          if (lat_cnt == 2'd0) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
            if (lat_cnt == 2'd1) begin
              i_rvalid_q <= !owner_d;
              d_rvalid_q <= owner_d;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = '0; b1.d_wdata = '0; b1.d_be = '0; b1.mem_rdata = '0;
        b3.i_req = 0; b3.i_addr = '0; b3.d_req = 0; b3.d_we = 0;
        b3.d_addr = '0; b3.d_wdata = '0; b3.d_be = '0; b3.mem_rdata = '0;
    endtask

    initial begin
        int exp_cnt [6];
        exp_cnt = '{0, 1, 2, 3, 4, 0};
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        #2;
        chk("reset busy",   b1.busy,     1'b0);
        chk("reset i_gnt",  b1.i_gnt,    1'b0);
        chk("reset mem_en", b1.mem_en,   1'b0);
        chk("reset addr",   b1.mem_addr, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();

        // Single fetch, MEM_LAT=1
        b1.i_req = 1; b1.i_addr = 32'h8000_0000;
        #1;
        chk("fetch gnt",   b1.i_gnt, 1'b1);
        chk("fetch d_gnt", b1.d_gnt, 1'b0);
        nxt();
        b1.i_req = 0; b1.i_addr = 32'h0000_1234;
        #1;
        chk("fetch mem_en",   b1.mem_en,   1'b1);
        chk("fetch mem_addr", b1.mem_addr, 32'h8000_0000);
        chk("fetch mem_we",   b1.mem_we,   1'b0);
        chk("fetch mem_be",   b1.mem_be,   4'hF);
        chk("fetch busy",     b1.busy,     1'b1);
        b1.mem_rdata = 32'h0000_0013;
        nxt();
        #1;
        chk("fetch rvalid",   b1.i_rvalid, 1'b1);
        chk("fetch rdata",    b1.i_rdata,  32'h0000_0013);
        chk("fetch d_rvalid", b1.d_rvalid, 1'b0);
        chk("fetch en low",   b1.mem_en,   1'b0);
        nxt();
        #1;
        chk("fetch rvalid off", b1.i_rvalid, 1'b0);
        chk("fetch rdata off",  b1.i_rdata,  32'h0);
        chk("fetch idle",       b1.busy,     1'b0);

        // Simultaneous requests: store wins, fetch follows
        b1.i_req = 1; b1.i_addr = 32'h8000_0004;
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h8000_0100;
        b1.d_wdata = 32'hDEAD_BEEF; b1.d_be = 4'hF;
        #1;
        chk("both d_gnt", b1.d_gnt, 1'b1);
        chk("both i_gnt", b1.i_gnt, 1'b0);
        nxt();
        b1.d_req = 0; b1.d_wdata = 32'h0;
        #1;
        chk("store mem_en",    b1.mem_en,    1'b1);
        chk("store mem_we",    b1.mem_we,    1'b1);
        chk("store mem_addr",  b1.mem_addr,  32'h8000_0100);
        chk("store mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        chk("store i_gnt",     b1.i_gnt,     1'b0);
        b1.mem_rdata = 32'h5555_5555;
        nxt();
        #1;
        chk("store rvalid", b1.d_rvalid, 1'b1);
        chk("store rdata",  b1.d_rdata,  32'h0);
        chk("store i_gnt2", b1.i_gnt,    1'b0);
        nxt();
        #1;
        chk("after store i_gnt",  b1.i_gnt,      1'b1);
        chk("after store starve", u1.starve_cnt, 4'd1);
        nxt();
        b1.i_req = 0;
        nxt();
        nxt();

        // Starvation: both held, four data grants then one fetch
        b1.i_req = 1; b1.i_addr = 32'h8000_0008;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h8000_0010; b1.d_be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("starve i_gnt", b1.i_gnt,      1'(k == 4));
            chk("starve d_gnt", b1.d_gnt,      1'(k != 4));
            chk("starve cnt",   u1.starve_cnt, 4'(exp_cnt[k]));
            nxt();
            nxt();
            nxt();
        end
        b1.i_req = 0; b1.d_req = 0;
        nxt();

        // Fetch request raised and dropped while a load is busy
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h8000_0020;
        #1;
        chk("drop d_gnt", b1.d_gnt, 1'b1);
        nxt();
        b1.d_req = 0; b1.i_req = 1; b1.i_addr = 32'h8000_0030;
        #1;
        chk("drop i_gnt busy", b1.i_gnt, 1'b0);
        nxt();
        b1.i_req = 0;
        #1;
        chk("drop i_gnt cmpl", b1.i_gnt,    1'b0);
        chk("drop d_rvalid",   b1.d_rvalid, 1'b1);
        nxt();
        #1;
        chk("drop idle",   b1.busy,       1'b0);
        chk("drop starve", u1.starve_cnt, 4'd0);
        nxt();
        #1;
        chk("drop no access", b1.mem_en, 1'b0);

        // MEM_LAT=3 load, fetch pending behind it
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h8000_0200; b3.d_be = 4'hF;
        #1;
        chk("lat3 d_gnt", b3.d_gnt, 1'b1);
        nxt();
        b3.d_req = 0; b3.i_req = 1; b3.i_addr = 32'h8000_0300;
        #1;
        chk("lat3 mem_en c1", b3.mem_en,   1'b1);
        chk("lat3 addr c1",   b3.mem_addr, 32'h8000_0200);
        chk("lat3 busy c1",   b3.busy,     1'b1);
        chk("lat3 i_gnt c1",  b3.i_gnt,    1'b0);
        nxt();
        #1;
        chk("lat3 mem_en c2", b3.mem_en,   1'b0);
        chk("lat3 rvalid c2", b3.d_rvalid, 1'b0);
        chk("lat3 busy c2",   b3.busy,     1'b1);
        nxt();
        b3.mem_rdata = 32'hCAFE_0001;
        #1;
        chk("lat3 rvalid c3", b3.d_rvalid, 1'b0);
        chk("lat3 i_gnt c3",  b3.i_gnt,    1'b0);
        nxt();
        #1;
        chk("lat3 rvalid c4",   b3.d_rvalid, 1'b1);
        chk("lat3 rdata c4",    b3.d_rdata,  32'hCAFE_0001);
        chk("lat3 i_rvalid c4", b3.i_rvalid, 1'b0);
        chk("lat3 i_rdata c4",  b3.i_rdata,  32'h0);
        chk("lat3 busy c4",     b3.busy,     1'b1);
        chk("lat3 i_gnt c4",    b3.i_gnt,    1'b0);
        nxt();
        #1;
        chk("lat3 rvalid c5", b3.d_rvalid, 1'b0);
        chk("lat3 busy c5",   b3.busy,     1'b0);
        chk("lat3 i_gnt c5",  b3.i_gnt,    1'b1);
        nxt();
        b3.i_req = 0;
        #1;
        chk("lat3 fetch addr", b3.mem_addr, 32'h8000_0300);
        nxt();
        nxt();
        nxt();
        #1;
        chk("lat3 fetch rvalid", b3.i_rvalid, 1'b1);
        chk("lat3 fetch rdata",  b3.i_rdata,  32'hCAFE_0001);
        nxt();
        #1;
        chk("lat3 fetch idle", b3.busy, 1'b0);

        // Reset in WAIT aborts the load; pending fetch granted right after
        b3.d_req = 1; b3.d_addr = 32'h8000_0400;
        #1;
        chk("abort d_gnt", b3.d_gnt, 1'b1);
        nxt();
        b3.d_req = 0;
        nxt();
        rst = 1'b1; b3.i_req = 1;
        #1;
        chk("abort busy",     b3.busy,     1'b0);
        chk("abort mem_en",   b3.mem_en,   1'b0);
        chk("abort mem_addr", b3.mem_addr, 32'h0);
        chk("abort d_rvalid", b3.d_rvalid, 1'b0);
        chk("abort i_gnt",    b3.i_gnt,    1'b0);
        nxt();
        rst = 1'b0;
        #1;
        chk("post rst i_gnt",    b3.i_gnt,    1'b1);
        chk("post rst d_rvalid", b3.d_rvalid, 1'b0);
        nxt();
        b3.i_req = 0;
        #1;
        chk("post rst d_rvalid c4", b3.d_rvalid, 1'b0);
        chk("post rst mem_addr",    b3.mem_addr, 32'h8000_0300);
        nxt();
        #1;
        chk("post rst d_rvalid c5", b3.d_rvalid, 1'b0);
        nxt();
        #1;
        chk("post rst d_rvalid c6", b3.d_rvalid, 1'b0);
        nxt();
        #1;
        chk("post rst i_rvalid", b3.i_rvalid, 1'b1);
        chk("post rst d_rvalid", b3.d_rvalid, 1'b0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requesters and the RAM port.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
REQ-004 Parameter STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; legal range 1..15.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Ports i_req in 1, i_addr in ADDR_W: instruction-fetch request and address (read only).
REQ-008 Ports i_gnt out 1, i_rvalid out 1, i_rdata out DATA_W: fetch grant, read-data valid strobe, read data.
REQ-009 Ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_be in DATA_W/8: data load/store request.
REQ-010 Ports d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W: data grant, completion strobe, load data.
REQ-011 Ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_be out DATA_W/8, mem_rdata in DATA_W: single-port RAM.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States: IDLE, ACCESS, WAIT; exactly one RAM transaction outstanding.
REQ-014 IDLE: gnt is combinational, asserted in the same cycle a request is seen; at most one of i_gnt/d_gnt high.
REQ-015 Priority: d wins when both request, unless starve counter == STARVE_MAX, then i wins.
REQ-016 Starve counter: +1 (saturating at STARVE_MAX) on a d grant while i_req high; cleared on i grant or on a d grant with i_req low.
REQ-017 On a grant at cycle T: address, we, wdata, be (fetch: we=0, be all ones, wdata=0) and owner latched; state -> ACCESS.
REQ-018 ACCESS (T+1): mem_en=1 with latched values for exactly one cycle; then WAIT.
REQ-019 WAIT counts MEM_LAT-1 further cycles; completion cycle is T+1+MEM_LAT.
REQ-020 Completion cycle: owner's rvalid=1 for one cycle, owner's rdata = mem_rdata (combinational pass-through); non-owner rvalid=0; next state IDLE.
REQ-021 Stores also complete with d_rvalid=1 at T+1+MEM_LAT; d_rdata is don't-care for stores and drives 0.
REQ-022 No grant in ACCESS/WAIT or in the completion cycle; earliest next grant is T+2+MEM_LAT.
REQ-023 Requesters hold req and payload until gnt; payload changes after gnt do not affect the transaction.
REQ-024 Request dropped before grant: no transaction, no counter change.
REQ-025 mem_en, mem_we low outside ACCESS; mem_addr/wdata/be hold last latched values.
REQ-026 i_rdata/d_rdata drive 0 when their rvalid is low.

Reset
REQ-027 rst high forces state IDLE, starve counter 0, latched registers 0, all outputs 0, immediately (asynchronous).
REQ-028 rst during ACCESS/WAIT aborts the transaction: no rvalid ever issued for it; first grant possible in first cycle after rst deasserts.

Verification
REQ-029 MEM_LAT=1, i_req with i_addr=0x8000_0000 at cycle 0 -> i_gnt cycle 0, mem_en/addr=0x8000_0000 cycle 1, i_rvalid with mem_rdata=0x0000_0013 cycle 2.
REQ-030 Both req at cycle 0, d_we=1, d_addr=0x8000_0100, d_wdata=0xDEAD_BEEF, d_be=0xF -> d_gnt cycle 0, mem_we=1 cycle 1, d_rvalid cycle 2, i_gnt cycle 3.
REQ-031 STARVE_MAX=4, d_req and i_req held continuously -> d granted 4 times, 5th grant to i, then d again; counter 0 after i grant.
REQ-032 MEM_LAT=3, d load 0x8000_0200 -> mem_en cycle 1, d_rvalid cycle 4 only, busy high cycles 1-4, next grant cycle 5.
REQ-033 rst pulsed in WAIT (MEM_LAT=3, cycle 2) -> all outputs 0 at once, no d_rvalid, pending i_req granted first cycle after rst low.
REQ-034 i_req dropped at cycle 0 while d transaction busy -> no i_gnt, no memory access for fetch, counter unchanged.
